// File: rtl/axi_rd_sched.sv
// axi_rd_sched: round-robin AR arbiter feeding one master read port, in-order R steering via pending FIFO; optional sticky watchdog under AXI_RD_SCHED_TIMEOUT_EN
module axi_rd_sched #(
  parameter int Ports = 2,
  parameter int DataBits = 64,
  parameter int AddrBits = 32,
  parameter int LenBits = 4,
  parameter int NumPendingReads = 6,
  parameter int TimeoutCycles = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [Ports-1:0]                       slv_arvalid,
  output logic [Ports-1:0]                       slv_arready,
  input  logic [Ports*AddrBits-1:0]              slv_araddr,
  input  logic [Ports*LenBits-1:0]               slv_arlen,
  output logic [Ports-1:0]                       slv_rvalid,
  input  logic [Ports-1:0]                       slv_rready,
  output logic [Ports*DataBits-1:0]              slv_rdata,
  output logic [Ports*2-1:0]                     slv_rresp,
  output logic [Ports-1:0]                       slv_rlast,
  output logic                                   mst_arvalid,
  input  logic                                   mst_arready,
  output logic [AddrBits-1:0]                    mst_araddr,
  output logic [LenBits-1:0]                     mst_arlen,
  input  logic                                   mst_rvalid,
  output logic                                   mst_rready,
  input  logic [DataBits-1:0]                    mst_rdata,
  input  logic [1:0]                             mst_rresp,
  input  logic                                   mst_rlast,
  output logic [$clog2(NumPendingReads+1)-1:0]   pend_count,
  output logic                                   timeout_err
);
  localparam int PW = $clog2(Ports);
  localparam int CW = $clog2(NumPendingReads + 1);
  localparam int FW = NumPendingReads > 1 ? $clog2(NumPendingReads) : 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, win, cand, head;
  logic [AddrBits-1:0] addr_q, addr_d;
  logic [LenBits-1:0] len_q, len_d;
  logic [FW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] mem_q [NumPendingReads];
  logic [PW-1:0] mem_d [NumPendingReads];
  logic found, empty, full, push, pop;
  always_comb begin
    win = ptr_q;
    found = 1'b0;
    cand = ptr_q;
    for (int i = 0; i < Ports; i++) begin
      cand = (cand == PW'(Ports - 1)) ? '0 : cand + PW'(1);
      if (!found && slv_arvalid[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
  end
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(NumPendingReads);
  assign head = mem_q[rd_q];
  assign slv_arready = (state_q == IDLE && found && !full && !rst) ? Ports'(1) << win : '0;
  assign mst_arvalid = state_q == ISSUE;
  assign push = mst_arvalid && mst_arready;
  assign slv_rvalid = empty ? '0 : Ports'(mst_rvalid) << head;
  assign mst_rready = !empty && slv_rready[head];
  assign pop = mst_rvalid && mst_rready && mst_rlast;
  assign slv_rdata = {Ports{mst_rdata}};
  assign slv_rresp = {Ports{mst_rresp}};
  assign slv_rlast = {Ports{mst_rlast}};
  assign mst_araddr = addr_q;
  assign mst_arlen = len_q;
  assign pend_count = cnt_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    addr_d = addr_q;
    len_d = len_q;
    if (|slv_arready) begin
      addr_d = slv_araddr[win*AddrBits +: AddrBits];
      len_d = slv_arlen[win*LenBits +: LenBits];
      idx_d = win;
      ptr_d = win;
      state_d = ISSUE;
    end
    if (push) state_d = IDLE;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = idx_q;
    wr_d = push ? ((wr_q == FW'(NumPendingReads - 1)) ? '0 : wr_q + FW'(1)) : wr_q;
    rd_d = pop ? ((rd_q == FW'(NumPendingReads - 1)) ? '0 : rd_q + FW'(1)) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= PW'(Ports - 1);
      idx_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      len_q <= len_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
`ifdef AXI_RD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic err_q, err_d;
  always_comb begin
    wd_d = (empty || (mst_rvalid && mst_rready)) ? '0 : (wd_q == TW'(TimeoutCycles)) ? wd_q : wd_q + TW'(1);
    err_d = err_q || wd_d == TW'(TimeoutCycles);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      err_q <= err_d;
    end
  end
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif
endmodule
